// File: rtl/avalon_pio_pkg.sv
// Shared constants for the Avalon-MM GPIO port.
// Register word addresses and edge-capture modes.
package avalon_pio_pkg;

    localparam logic [2:0] ADDR_DATA    = 3'd0;
    localparam logic [2:0] ADDR_DIR     = 3'd1;
    localparam logic [2:0] ADDR_IRQMASK = 3'd2;
    localparam logic [2:0] ADDR_EDGE    = 3'd3;
    localparam logic [2:0] ADDR_OUTSET  = 3'd4;
    localparam logic [2:0] ADDR_OUTCLR  = 3'd5;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

    function automatic int prime_limit(int sync_stages);
        return sync_stages + 1;
    endfunction

endpackage

// File: rtl/pio_sync_edge.sv
// Input synchroniser, previous-sample flop and primed edge detector.
// Edges are held off until the chain has flushed its reset contents.
module pio_sync_edge
    import avalon_pio_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = EDGE_RISE
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] in_sync,
    output logic [WIDTH-1:0] edge_det
);

    localparam int PRIME_MAX = prime_limit(SYNC_STAGES);
    localparam int CW        = $clog2(PRIME_MAX + 1);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0]                  in_prev;
    logic [CW-1:0]                     prime_cnt;
    logic                              primed;
    logic [WIDTH-1:0]                  rising;
    logic [WIDTH-1:0]                  falling;
    logic [WIDTH-1:0]                  edge_sel;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q    <= '0;
            in_prev   <= '0;
            prime_cnt <= '0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], in_port};
            in_prev <= in_sync;
            if (!primed)
                prime_cnt <= prime_cnt + CW'(1);
        end
    end

    assign in_sync = sync_q[SYNC_STAGES-1];
    assign primed  = (prime_cnt == CW'(PRIME_MAX));
    assign rising  = in_sync & ~in_prev;
    assign falling = ~in_sync & in_prev;

    always_comb begin
        edge_sel = rising;
        if (EDGE_TYPE == EDGE_FALL)
            edge_sel = falling;
        else if (EDGE_TYPE == EDGE_ANY)
            edge_sel = rising | falling;
    end

    assign edge_det = primed ? edge_sel : '0;

endmodule

// File: rtl/avalon_pio_gpio.sv
// Parametrised Avalon-MM GPIO: data/direction/mask/capture registers,
// atomic set/clear of the output latch and a registered level irq.
module avalon_pio_gpio
    import avalon_pio_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter logic [WIDTH-1:0] DIR_RESET   = '0,
    parameter int               EDGE_TYPE   = EDGE_RISE,
    parameter int               SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] out_port,
    output logic [WIDTH-1:0] oe,
    output logic             irq
);

    logic             wr;
    logic [WIDTH-1:0] wdata;
    logic             unused_wdata;
    logic             wr_data;
    logic             wr_dir;
    logic             wr_mask;
    logic             wr_edge;
    logic             wr_set;
    logic             wr_clr;

    logic [WIDTH-1:0] data_out;
    logic [WIDTH-1:0] data_nxt;
    logic [WIDTH-1:0] direction;
    logic [WIDTH-1:0] irqmask;
    logic [WIDTH-1:0] edgecap;
    logic [WIDTH-1:0] clr_mask;
    logic [WIDTH-1:0] in_sync;
    logic [WIDTH-1:0] edge_det;
    logic [WIDTH-1:0] rd_word;

    assign wr           = chipselect & ~write_n;
    assign wdata        = writedata[WIDTH-1:0];
    assign unused_wdata = ^writedata;

    assign wr_data = wr && (address == ADDR_DATA);
    assign wr_dir  = wr && (address == ADDR_DIR);
    assign wr_mask = wr && (address == ADDR_IRQMASK);
    assign wr_edge = wr && (address == ADDR_EDGE);
    assign wr_set  = wr && (address == ADDR_OUTSET);
    assign wr_clr  = wr && (address == ADDR_OUTCLR);

    pio_sync_edge #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES),
        .EDGE_TYPE   (EDGE_TYPE)
    ) u_sync_edge (
        .clk      (clk),
        .reset    (reset),
        .in_port  (in_port),
        .in_sync  (in_sync),
        .edge_det (edge_det)
    );

    always_comb begin
        data_nxt = data_out;
        unique case (1'b1)
            wr_data: data_nxt = wdata;
            wr_set:  data_nxt = data_out | wdata;
            wr_clr:  data_nxt = data_out & ~wdata;
            default: data_nxt = data_out;
        endcase
    end

    assign clr_mask = wr_edge ? wdata : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_out  <= RESET_VALUE;
            direction <= DIR_RESET;
            irqmask   <= '0;
            edgecap   <= '0;
            irq       <= 1'b0;
        end else begin
            data_out <= data_nxt;
            if (wr_dir)
                direction <= wdata;
            if (wr_mask)
                irqmask <= wdata;
            // a fresh edge beats a same-cycle clear so nothing is lost
            edgecap <= edge_det | (edgecap & ~clr_mask);
            irq     <= |(edgecap & irqmask);
        end
    end

    always_comb begin
        rd_word = '0;
        unique case (1'b1)
            address == ADDR_DATA:
                rd_word = (direction & data_out) | (~direction & in_sync);
            address == ADDR_DIR:     rd_word = direction;
            address == ADDR_IRQMASK: rd_word = irqmask;
            address == ADDR_EDGE:    rd_word = edgecap;
            default:                 rd_word = '0;
        endcase
        readdata = 32'(rd_word);
    end

    assign out_port = data_out;
    assign oe       = direction;

endmodule

// File: tb/tb_avalon_pio_gpio.sv
// Randomised bench for avalon_pio_gpio against a history-based model,
// plus directed literal checks on an 8-bit and a 4-bit instance.
`timescale 1ns/1ps
module tb_avalon_pio_gpio;
    import avalon_pio_pkg::*;

    localparam int        W  = 8;
    localparam int        S  = 2;
    localparam logic [7:0] RV = 8'hA5;
    localparam logic [7:0] DR = 8'hFF;
    localparam int        W2 = 4;
    localparam int        S2 = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  address = '0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;

    logic [W-1:0]  in_port = '0;
    logic [W-1:0]  out_port, oe;
    logic [31:0]   readdata;
    logic          irq;
    logic [W2-1:0] in_port2 = '0;
    logic [W2-1:0] out_port2, oe2;
    logic [31:0]   readdata2;
    logic          irq2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    avalon_pio_gpio #(
        .WIDTH(W), .RESET_VALUE(RV), .DIR_RESET(DR),
        .EDGE_TYPE(EDGE_RISE), .SYNC_STAGES(S)
    ) dut (
        .clk(clk), .reset(reset), .address(address),
        .chipselect(chipselect), .write_n(write_n),
        .writedata(writedata), .readdata(readdata),
        .in_port(in_port), .out_port(out_port), .oe(oe), .irq(irq)
    );

    avalon_pio_gpio #(
        .WIDTH(W2), .RESET_VALUE(4'h0), .DIR_RESET(4'h0),
        .EDGE_TYPE(EDGE_ANY), .SYNC_STAGES(S2)
    ) dut2 (
        .clk(clk), .reset(reset), .address(address),
        .chipselect(chipselect), .write_n(write_n),
        .writedata(writedata), .readdata(readdata2),
        .in_port(in_port2), .out_port(out_port2), .oe(oe2), .irq(irq2)
    );

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Pad samples are kept newest-first; the synchronised view of the pad
    // is simply the sample taken S clocks ago.
    logic [W-1:0] m_out, m_dir, m_mask, m_cap;
    logic         m_irq;
    logic [W-1:0] m_hist[$];
    bit           cmp_en = 1'b0;

    function automatic logic [W-1:0] m_in_sync();
        if (m_hist.size() >= S)
            return m_hist[S-1];
        return '0;
    endfunction

    function automatic logic [31:0] m_read(logic [2:0] a);
        logic [W-1:0] v;
        v = '0;
        case (a)
            ADDR_DATA:    v = (m_dir & m_out) | (~m_dir & m_in_sync());
            ADDR_DIR:     v = m_dir;
            ADDR_IRQMASK: v = m_mask;
            ADDR_EDGE:    v = m_cap;
            default:      v = '0;
        endcase
        return {24'b0, v};
    endfunction

    task automatic m_reset();
        m_out  = RV;
        m_dir  = DR;
        m_mask = '0;
        m_cap  = '0;
        m_irq  = 1'b0;
        m_hist.delete();
    endtask

    task automatic m_step();
        logic [W-1:0] wd, ev, clr;
        logic         wr, nirq;
        wd  = writedata[W-1:0];
        wr  = chipselect & ~write_n;
        ev  = '0;
        clr = '0;
        // an edge is seen only once S+1 samples exist since reset
        if (m_hist.size() > S)
            ev = m_hist[S-1] & ~m_hist[S];
        if (wr && address == ADDR_EDGE)
            clr = wd;
        nirq  = |(m_cap & m_mask);
        m_cap = ev | (m_cap & ~clr);
        if (wr) begin
            case (address)
                ADDR_DATA:    m_out = wd;
                ADDR_DIR:     m_dir = wd;
                ADDR_IRQMASK: m_mask = wd;
                ADDR_OUTSET:  m_out = m_out | wd;
                ADDR_OUTCLR:  m_out = m_out & ~wd;
                default: ;
            endcase
        end
        m_irq = nirq;
        m_hist.push_front(in_port);
        if (m_hist.size() > S + 1)
            void'(m_hist.pop_back());
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset)
            m_reset();
        else
            m_step();
        cmp_en = 1'b1;
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("out_port", 32'(out_port), 32'(m_out));
            chk("oe", 32'(oe), 32'(m_dir));
            chk("irq", 32'(irq), 32'(m_irq));
            chk("readdata", readdata, m_read(address));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(int n = 1);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic bus(logic cs, logic wn, logic [2:0] a, logic [31:0] d);
        chipselect = cs;
        write_n    = wn;
        address    = a;
        writedata  = d;
    endtask

    task automatic wr_reg(logic [2:0] a, logic [31:0] d);
        bus(1'b1, 1'b0, a, d);
        tick();
        bus(1'b0, 1'b1, a, 32'h0);
    endtask

    task automatic rd_chk(string name, logic [2:0] a, logic [31:0] exp);
        bus(1'b1, 1'b1, a, 32'h0);
        #1;
        chk(name, readdata, exp);
    endtask

    task automatic rd2_chk(string name, logic [2:0] a, logic [31:0] exp);
        bus(1'b1, 1'b1, a, 32'h0);
        #1;
        chk(name, readdata2, exp);
    endtask

    initial begin
        tick(3);
        reset = 1'b0;
        tick();

        // reset state
        chk("rst_out_port", 32'(out_port), 32'h0000_00A5);
        chk("rst_oe", 32'(oe), 32'h0000_00FF);
        chk("rst_irq", 32'(irq), 32'h0);
        rd_chk("rst_read_data", ADDR_DATA, 32'h0000_00A5);
        chk("rst_oe2", 32'(oe2), 32'h0);

        // data, set, clear
        wr_reg(ADDR_DATA, 32'h0F);
        chk("wr_data", 32'(out_port), 32'h0F);
        wr_reg(ADDR_OUTSET, 32'h30);
        chk("outset", 32'(out_port), 32'h3F);
        wr_reg(ADDR_OUTCLR, 32'h05);
        chk("outclr", 32'(out_port), 32'h3A);

        // rising capture and irq
        wr_reg(ADDR_DIR, 32'h00);
        wr_reg(ADDR_IRQMASK, 32'h01);
        tick(3);
        in_port = 8'h01;
        tick(2);
        rd_chk("cap_early", ADDR_EDGE, 32'h0);
        tick(1);
        rd_chk("cap_set", ADDR_EDGE, 32'h1);
        chk("irq_lag", 32'(irq), 32'h0);
        tick(1);
        chk("irq_set", 32'(irq), 32'h1);
        wr_reg(ADDR_EDGE, 32'h01);
        rd_chk("cap_clr", ADDR_EDGE, 32'h0);
        chk("irq_hold", 32'(irq), 32'h1);
        tick(1);
        chk("irq_clr", 32'(irq), 32'h0);

        // new edge and clear landing together: the set wins
        in_port = 8'h00;
        tick(4);
        rd_chk("no_fall_cap", ADDR_EDGE, 32'h0);
        in_port = 8'h01;
        tick(2);
        bus(1'b1, 1'b0, ADDR_EDGE, 32'h01);
        tick(1);
        bus(1'b0, 1'b1, ADDR_DATA, 32'h0);
        rd_chk("set_wins", ADDR_EDGE, 32'h1);
        tick(1);
        chk("irq_set_wins", 32'(irq), 32'h1);
        wr_reg(ADDR_EDGE, 32'hFF);
        tick(1);

        // async reset, then high pads held through release
        in_port = 8'hFF;
        reset = 1'b1;
        #1;
        chk("async_out_port", 32'(out_port), 32'hA5);
        chk("async_oe", 32'(oe), 32'hFF);
        chk("async_irq", 32'(irq), 32'h0);
        rd_chk("async_mask", ADDR_IRQMASK, 32'h0);
        tick(2);
        reset = 1'b0;
        wr_reg(ADDR_IRQMASK, 32'hFF);
        wr_reg(ADDR_DIR, 32'h00);
        tick(8);
        rd_chk("prime_cap", ADDR_EDGE, 32'h0);
        chk("prime_irq", 32'(irq), 32'h0);
        rd_chk("prime_data", ADDR_DATA, 32'hFF);

        // narrow instance: masking, unused addresses, any-edge
        wr_reg(ADDR_DIR, 32'hFFFF_FFFF);
        rd2_chk("w4_dir", ADDR_DIR, 32'h0000_000F);
        rd_chk("w8_dir", ADDR_DIR, 32'h0000_00FF);
        rd2_chk("w4_addr6", 3'd6, 32'h0);
        rd_chk("w8_addr6", 3'd6, 32'h0);
        rd_chk("w8_outset_rd", ADDR_OUTSET, 32'h0);
        in_port2 = 4'b0010;
        tick(3);
        rd2_chk("w4_cap_early", ADDR_EDGE, 32'h0);
        tick(1);
        rd2_chk("w4_cap_rise", ADDR_EDGE, 32'h2);
        wr_reg(ADDR_EDGE, 32'hF);
        rd2_chk("w4_cap_clr", ADDR_EDGE, 32'h0);
        in_port2 = 4'b0000;
        tick(4);
        rd2_chk("w4_cap_fall", ADDR_EDGE, 32'h2);

        // reset lands on an in-flight write
        bus(1'b1, 1'b0, ADDR_DATA, 32'h55);
        #1;
        reset = 1'b1;
        #1;
        chk("inflight_out", 32'(out_port), 32'hA5);
        chk("inflight_oe2", 32'(oe2), 32'h0);
        rd2_chk("inflight_cap2", ADDR_EDGE, 32'h0);
        tick(2);
        reset = 1'b0;
        tick(1);
        chk("write_lost", 32'(out_port), 32'hA5);

        // random traffic checked by the model
        for (int i = 0; i < 3000; i++) begin
            if (reset)
                reset = 1'b0;
            else if ($urandom_range(0, 399) == 0)
                reset = 1'b1;
            chipselect = 1'($urandom);
            write_n    = 1'($urandom);
            address    = 3'($urandom);
            writedata  = $urandom;
            if ($urandom_range(0, 3) == 0)
                in_port = 8'($urandom);
            tick();
        end

        bus(1'b0, 1'b1, ADDR_DATA, 32'h0);
        reset = 1'b0;
        tick(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/avalon_pio_gpio.md
Name: avalon_pio_gpio

Overview:
Parametrised Avalon-MM general-purpose I/O port. It is the successor to the fixed 8-bit output-only PIO and sits on the same system-interconnect slave as its predecessor. It adds:
- configurable width
- per-bit direction (bidirectional I/O, with the output enable exported to pad logic)
- input synchronisation
- edge capture with a maskable interrupt
- atomic bit-set and bit-clear of the output register

Parameters:
WIDTH, 8, number of I/O bits, legal 1..32.
RESET_VALUE, 0, reset value of the output data register (WIDTH bits).
DIR_RESET, 0, reset value of the direction register; 1 = output.
EDGE_TYPE, 0, capture mode: 0 rising, 1 falling, 2 any edge.
SYNC_STAGES, 2, input synchroniser depth, legal 2..4.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
address  in  3  register word select
chipselect  in  1  slave select
write_n  in  1  active-low write strobe, qualified by chipselect
writedata  in  32  write data
readdata  out  32  read data, read latency 0 (combinational from registers)
in_port  in  WIDTH  asynchronous pad inputs
out_port  out  WIDTH  output data register
oe  out  WIDTH  per-bit output enable = direction register
irq  out  1  level interrupt, active-high

Behaviour:
- Clock and reset: single clock clk; reset is asynchronous and active-high.
- Reset values:
  - data_out = RESET_VALUE; direction = DIR_RESET.
  - irqmask = 0; edgecapture = 0; synchroniser flops = 0.
  - prime counter = 0; irq = 0.
- Write: wr = chipselect & ~write_n. Each write takes effect on the next clk edge.
- Register map, word addresses:
  - 0 DATA. Read: bit i = direction[i] ? data_out[i] : in_sync[i]. Write: data_out <= writedata[WIDTH-1:0].
  - 1 DIRECTION. Read/write, WIDTH bits.
  - 2 IRQMASK. Read/write, WIDTH bits.
  - 3 EDGECAPTURE. Read returns captured bits. Write is write-1-to-clear per bit.
  - 4 OUTSET. Write only: data_out <= data_out | writedata. Reads 0.
  - 5 OUTCLEAR. Write only: data_out <= data_out & ~writedata. Reads 0.
  - 6, 7: reads return 0; writes ignored.
- readdata bits 31..WIDTH are always 0. Reads have no side effects.
- Synchroniser: in_port passes through a chain of SYNC_STAGES flops, giving in_sync. One further flop, in_prev, holds last cycle's in_sync.
- Edge detection:
  - rising = in_sync & ~in_prev
  - falling = ~in_sync & in_prev
  - any = rising | falling
- Edges are evaluated on all bits regardless of direction, so output bits loop back via the pad.
- Prime counter: counts from 0 to SYNC_STAGES+1 after reset, then saturates. Edge detection is suppressed until saturation. This prevents a high input at reset release from producing a spurious capture.
- Edge capture: edgecapture[i] <= edge[i] | (edgecapture[i] & ~clr[i]). clr is the EDGECAPTURE write mask.
- Simultaneous new edge and clear on the same bit: the set wins, so no edge is lost.
- Total latency from a pad transition to edgecapture set: SYNC_STAGES+1 clk cycles.
- irq = |(edgecapture & irqmask), registered, so it asserts one cycle after edgecapture is set.
- Clearing the last masked capture deasserts irq one cycle after the clearing write's edge. Clearing irqmask has the same effect.
- Bits of writedata at or above WIDTH are ignored on every register.
- Reset asserted mid-operation: all state returns to reset values asynchronously. An in-flight write is lost.

Decomposition:
- Package avalon_pio_pkg holds:
  - address constants ADDR_DATA=0, ADDR_DIR=1, ADDR_IRQMASK=2, ADDR_EDGE=3, ADDR_OUTSET=4, ADDR_OUTCLR=5
  - edge-type constants EDGE_RISE=0, EDGE_FALL=1, EDGE_ANY=2
- Sub-module pio_sync_edge (parameters WIDTH, SYNC_STAGES, EDGE_TYPE) contains the synchroniser, in_prev, prime counter and edge output. It is instantiated once.
- The top level contains the registers, read mux and irq.

Test Plan:
1. Reset with RESET_VALUE=0xA5, DIR_RESET=0xFF -> out_port=0xA5, oe=0xFF, irq=0. Read addr 0 -> 0x000000A5.
2. Write addr0=0x0F, then addr4=0x30, then addr5=0x05 -> out_port sequence 0x0F, 0x3F, 0x3A, each one cycle after its write.
3. Direction=0x00, EDGE_TYPE=0, irqmask=0x01; drive in_port[0] 0->1 -> edgecapture=0x01 after 3 cycles, irq=1 one cycle later. Write 0x01 to addr3 -> irq=0.
4. in_port[0] rises in the same cycle as a write-1-to-clear of bit 0 reaches the capture stage -> edgecapture[0] stays 1.
5. in_port=0xFF held through reset release -> edgecapture stays 0x00 and irq stays 0 indefinitely.
6. WIDTH=4: write 0xFFFFFFFF to addr 1, then read addr 1 -> 0x0000000F. Read addr 6 -> 0. Assert reset mid-sequence -> every register returns to its reset value immediately.
